spi_reg_controller: RTL and testbench
=====================================

Name: spi_reg_controller

Overview:
- SPI controller (initiator) for the onboarding register interface.
- Serialises one 16-bit register-write frame per request: rw bit, 7-bit address, 8-bit data.
- Drives ncs/sclk/copi toward the SPI peripheral's ui_in pins. Used as the bench-side and on-chip driver that programs the peripheral's output-enable and PWM registers.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
- CLK_DIV, 4, system clocks per SCLK half-period. Minimum 3, because the peripheral synchronises SCLK with a 2-flop synchroniser.
- CS_SETUP, 2, clocks with ncs low and sclk low before the first rising SCLK edge. Minimum 1.
- CS_HOLD, 2, clocks with sclk low after the last falling SCLK edge before ncs rises. Minimum 1.

Ports:
- clk  in  1  system clock. All logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a frame. Sampled only while idle.
- rw  in  1  frame bit 15 (1 = write).
- addr  in  7  register address, frame bits 14:8.
- wdata  in  8  write data, frame bits 7:0.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame completion.
- ncs  out  1  chip select, active low.
- sclk  out  1  SPI clock, idles low.
- copi  out  1  controller-out data.
- cipo  in  1  peripheral-out data. Present only with SPI_READBACK_EN.
- rdata  out  8  captured read byte. Present only with SPI_READBACK_EN.

Behaviour:
- Reset (asynchronous, immediate):
  - ncs=1, sclk=0, copi=0, busy=0, done=0, rdata=0.
  - State = IDLE; all counters cleared.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - On the rising edge where start=1, latch frame = {rw, addr, wdata}.
  - Same edge: ncs<=0, busy<=1, copi<=frame[15]; enter SETUP.
- SETUP: hold for CS_SETUP cycles with sclk=0, then enter SHIFT at bit 15.
- SHIFT, per bit (16 bits, 15 down to 0):
  - CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
  - copi is updated on the same edge that sclk falls, so it is stable for the whole high phase. Bit 15 was already driven in IDLE.
  - After the high phase of bit 0: sclk<=0, enter HOLD.
- Frame and edges:
  - Exactly 16 rising SCLK edges per frame; copi never changes while sclk=1.
  - copi after the last bit holds bit 0 until ncs rises, then goes to 0.
- HOLD: CS_HOLD cycles with sclk=0, ncs=0; then ncs<=1, enter GAP.
- GAP:
  - CLK_DIV cycles with ncs=1 (minimum inter-frame deselect).
  - Then busy<=0 and done<=1 for exactly one cycle; return to IDLE.
- Busy duration: exactly CS_SETUP + 32*CLK_DIV + CS_HOLD + CLK_DIV cycles. Defaults give 136.
- start while busy: ignored, no queuing. Changes to rw/addr/wdata mid-frame have no effect.
- start=1 on the done cycle: accepted (state is IDLE). Consecutive frames are separated by at least CS_HOLD + CLK_DIV cycles of sclk low and CLK_DIV cycles of ncs high.
- Reset mid-frame:
  - Frame is aborted and ncs rises asynchronously; no done pulse.
  - The peripheral discards the partial frame on the ncs rise.
- rw=0 frames are shifted out identically; the peripheral ignores them.

Optional Feature:
- Macro: SPI_READBACK_EN.
- When defined:
  - The cipo and rdata ports exist.
  - cipo is sampled on the clk edge where sclk goes 0->1 for bits 7..0, shifted MSB first into a shadow register.
  - rdata updates from the shadow register on the done cycle and holds until the next done or rst.
  - Sampling happens for every frame, whatever rw is.
- When undefined: no cipo/rdata ports and no shadow register; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-simulation -> ncs=1, sclk=0, copi=0, busy=0, done=0 without waiting for clk.
- Single write, rw=1, addr=0x00, wdata=0xF0:
  - Decode copi at each sclk rise -> 0x80F0, exactly 16 rises.
  - busy high for 136 cycles; done pulses once, 1 cycle wide.
  - First sclk rise at CS_SETUP+CLK_DIV = 6 cycles after ncs falls.
- Back-to-back frames with start held high, frames 0x8101 then 0x82AA:
  - Second frame's ncs falls the cycle after done.
  - ncs high for >=4 cycles between frames; both frames decode correctly.
- start pulsed and addr/wdata changed while busy (at bit 10) -> in-flight frame unchanged, no extra frame.
- Assert rst during the high phase of bit 8 -> ncs rises immediately, no done. The next start produces a complete, correct frame.
- With SPI_READBACK_EN, rw=0 frame, cipo modelled as a mode-0 peripheral returning 0xA5 in the data phase -> rdata=0xA5 on the done cycle and held afterwards.

Source files
------------

// File: rtl/spi_reg_controller_if.sv
// Signal bundle for spi_reg_controller: request/status handshake plus SPI pins.
// master: the controller's view (drives status and the SPI clock, select and data pins).
// slave:  the requester/peripheral view (drives start and the frame fields, samples status).
// When SPI_READBACK_EN is defined, cipo (peripheral data) and rdata (captured byte) are added.
interface spi_reg_controller_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       ncs;
    logic       sclk;
    logic       copi;
`ifdef SPI_READBACK_EN
    logic       cipo;
    logic [7:0] rdata;

    modport master (
        input  start, rw, addr, wdata, cipo,
        output busy, done, ncs, sclk, copi, rdata
    );
    modport slave (
        output start, rw, addr, wdata, cipo,
        input  busy, done, ncs, sclk, copi, rdata
    );
`else
    modport master (
        input  start, rw, addr, wdata,
        output busy, done, ncs, sclk, copi
    );
    modport slave (
        output start, rw, addr, wdata,
        input  busy, done, ncs, sclk, copi
    );
`endif
endinterface

// File: rtl/spi_reg_controller.sv
// SPI initiator for the register interface: sends one 16-bit frame {rw, addr[6:0], wdata[7:0]}
// per start request, SPI mode 0, MSB first. All pin outputs are registered.
// CLK_DIV (>= 3) is system clocks per SCLK half-period; CS_SETUP/CS_HOLD (>= 1) pad the
// chip-select window before the first rising and after the last falling SCLK edge.
// Optional macro SPI_READBACK_EN: adds cipo/rdata and captures the last 8 bits of cipo.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ncs high, waiting for start
// ST_SETUP | ncs low, sclk low, CS_SETUP cycles before the first bit
// ST_SHIFT | 16 bits, each CLK_DIV cycles low then CLK_DIV cycles high
// ST_HOLD  | sclk low, ncs still low, CS_HOLD cycles
// ST_GAP   | ncs high for CLK_DIV cycles, then done pulse
module spi_reg_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_reg_controller_if.master bus
);

    localparam int CNT_MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int CNT_MAX   = (CNT_MAX_A > CS_HOLD) ? CNT_MAX_A : CS_HOLD;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] LOAD_DIV   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LOAD_SETUP = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] LOAD_HOLD  = CNT_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [15:0]      frame_q, frame_d;
    logic             ncs_q, ncs_d;
    logic             sclk_q, sclk_d;
    logic             copi_q, copi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SPI_READBACK_EN
    logic [7:0]       shadow_q, shadow_d;
    logic [7:0]       rdata_q, rdata_d;
`endif

    // Register all state, counters and pin outputs; reset forces the bus idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            frame_q  <= '0;
            ncs_q    <= 1'b1;
            sclk_q   <= 1'b0;
            copi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SPI_READBACK_EN
            shadow_q <= '0;
            rdata_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            ncs_q    <= ncs_d;
            sclk_q   <= sclk_d;
            copi_q   <= copi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SPI_READBACK_EN
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
`endif
        end
    end

    // Next-state and next-output logic; sclk falls and copi advances on the same edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        ncs_d    = ncs_q;
        sclk_d   = sclk_q;
        copi_d   = copi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SPI_READBACK_EN
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    frame_d = {bus.rw, bus.addr, bus.wdata};
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    copi_d  = bus.rw;
                    cnt_d   = LOAD_SETUP;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = LOAD_DIV;
                    bit_d   = 4'd15;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                    cnt_d  = LOAD_DIV;
`ifdef SPI_READBACK_EN
                    // Data phase (bits 7..0): capture cipo on the rising SCLK edge.
                    if (!bit_q[3]) begin
                        shadow_d = {shadow_q[6:0], bus.cipo};
                    end
`endif
                end else begin
                    sclk_d = 1'b0;
                    if (bit_q == 4'd0) begin
                        cnt_d   = LOAD_HOLD;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d  = LOAD_DIV;
                        bit_d  = bit_q - 4'd1;
                        copi_d = frame_q[bit_d];
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                    cnt_d   = LOAD_DIV;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef SPI_READBACK_EN
                    rdata_d = shadow_q;
`endif
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.ncs  = ncs_q;
    assign bus.sclk = sclk_q;
    assign bus.copi = copi_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef SPI_READBACK_EN
    assign bus.rdata = rdata_q;
`endif

endmodule

// File: tb/tb_spi_reg_controller.sv
// Self-checking bench for spi_reg_controller (defaults CLK_DIV=4, CS_SETUP=2, CS_HOLD=2).
// Stimulus pushes expected frames into a queue; an independent monitor decodes the SPI pins
// and pops/compares each completed frame. Build with SPI_READBACK_EN to also check rdata.
module tb_spi_reg_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_reg_controller_if bus ();

    spi_reg_controller #(
        .CLK_DIV (4),
        .CS_SETUP(2),
        .CS_HOLD (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rd;
    } exp_t;

    exp_t       exp_q[$];
    int         checks    = 0;
    int         errors    = 0;
    int         done_cnt  = 0;
    int         frame_cnt = 0;
    logic [7:0] resp      = 8'h5A;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] f, input logic [7:0] rd);
        exp_t e;
        e.frame = f;
        e.rd    = rd;
        exp_q.push_back(e);
    endtask

`ifdef SPI_READBACK_EN
    // Mode-0 peripheral model: drives resp MSB first during the data phase while sclk is low.
    int   p_rises = 0;
    logic p_prev_sclk = 1'b0;
    initial bus.cipo = 1'b0;
    always @(negedge clk) begin
        if (rst || bus.ncs) begin
            p_rises = 0;
        end else if (bus.sclk && !p_prev_sclk) begin
            p_rises = p_rises + 1;
        end
        p_prev_sclk = bus.sclk;
        if (!rst && !bus.ncs && !bus.sclk && p_rises >= 8 && p_rises <= 15) begin
            bus.cipo = resp[15 - p_rises];
        end else if (bus.ncs) begin
            bus.cipo = 1'b0;
        end
    end
`endif

    // Monitor: decode frames from the pins, check timing, pop expectations on ncs rise.
    logic        m_prev_ncs  = 1'b1;
    logic        m_prev_sclk = 1'b0;
    logic        m_prev_copi = 1'b0;
    logic        m_prev_busy = 1'b0;
    logic        m_prev_done = 1'b0;
    bit          m_in_frame  = 1'b0;
    bit          m_copi_bad  = 1'b0;
    int          m_rises     = 0;
    int          m_cyc       = 0;
    int          m_first     = -1;
    int          m_busy_len  = 0;
    int          m_gap       = -1;
    logic [15:0] m_shift     = '0;
    exp_t        m_e;
`ifdef SPI_READBACK_EN
    logic [7:0]  m_exp_rd    = '0;
`endif

    always @(negedge clk) begin
        if (rst) begin
            m_in_frame = 1'b0;
            m_busy_len = 0;
            m_gap      = -1;
        end else begin
            if (m_in_frame) m_cyc++;
            if (m_gap >= 0 && bus.ncs) m_gap++;
            if (m_prev_ncs && !bus.ncs) begin
                if (m_gap >= 0) begin
                    checks++;
                    if (m_gap < 4) begin
                        errors++;
                        $display("FAIL ncs_gap: got %0d cycles high, expected >= 4", m_gap);
                    end
                end
                m_in_frame = 1'b1;
                m_cyc      = 0;
                m_rises    = 0;
                m_first    = -1;
                m_shift    = '0;
                m_copi_bad = 1'b0;
                m_gap      = -1;
            end
            if (m_in_frame && !bus.ncs) begin
                if (bus.sclk && !m_prev_sclk) begin
                    m_rises++;
                    m_shift = {m_shift[14:0], bus.copi};
                    if (m_first < 0) m_first = m_cyc;
                end
                if (bus.sclk && m_prev_sclk && bus.copi !== m_prev_copi) m_copi_bad = 1'b1;
            end
            if (m_in_frame && !m_prev_ncs && bus.ncs) begin
                m_in_frame = 1'b0;
                m_gap      = 1;
                frame_cnt++;
                chk("copi_zero_after_ncs", bus.copi, 0);
                chk("sclk_rises", m_rises, 16);
                chk("first_rise_latency", m_first, 6);
                chk("copi_stable_high", m_copi_bad, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_frame: got 0x%04h, expected no frame", m_shift);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("frame", m_shift, m_e.frame);
`ifdef SPI_READBACK_EN
                    m_exp_rd = m_e.rd;
`endif
                end
            end
            if (bus.busy) m_busy_len++;
            if (m_prev_busy && !bus.busy) begin
                chk("busy_len", m_busy_len, 136);
                m_busy_len = 0;
            end
            if (bus.done) begin
                done_cnt++;
                chk("busy_low_on_done", bus.busy, 0);
`ifdef SPI_READBACK_EN
                chk("rdata_on_done", bus.rdata, m_exp_rd);
`endif
            end
            if (m_prev_done) chk("done_width", bus.done, 0);
        end
        m_prev_ncs  = bus.ncs;
        m_prev_sclk = bus.sclk;
        m_prev_copi = bus.copi;
        m_prev_busy = bus.busy;
        m_prev_done = bus.done;
    end

    task automatic send(input logic r, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.rw    = r;
        bus.addr  = a;
        bus.wdata = d;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_ncs", bus.ncs, 0);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL %s: got no done within 400 cycles, expected done", name);
        end
    endtask

    task automatic wait_rises(input int k, input string name);
        int   r  = 0;
        int   n  = 0;
        logic ps = bus.sclk;
        while (r < k && n < 400) begin
            @(negedge clk);
            n++;
            if (bus.sclk && !ps) r++;
            ps = bus.sclk;
        end
        if (r < k) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d sclk rises, expected %0d", name, r, k);
        end
    endtask

    int dc;

    initial begin
        bus.start = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ncs", bus.ncs, 1);
        chk("idle_sclk", bus.sclk, 0);
        chk("idle_busy", bus.busy, 0);

        // Single write frame.
        push_exp(16'h80F0, 8'h5A);
        send(1'b1, 7'h00, 8'hF0);
        wait_done("single");
        @(negedge clk);

        // Back-to-back frames with start held high.
        push_exp(16'h8101, 8'h5A);
        push_exp(16'h82AA, 8'h5A);
        bus.rw    = 1'b1;
        bus.addr  = 7'h01;
        bus.wdata = 8'h01;
        bus.start = 1'b1;
        @(negedge clk);
        chk("b2b_first_busy", bus.busy, 1);
        bus.addr  = 7'h02;
        bus.wdata = 8'hAA;
        wait_done("b2b_first");
        @(negedge clk);
        chk("b2b_ncs_after_done", bus.ncs, 0);
        chk("b2b_busy_after_done", bus.busy, 1);
        bus.start = 1'b0;
        wait_done("b2b_second");
        @(negedge clk);

        // start and fields changed mid-frame at bit 10.
        push_exp(16'h953C, 8'h5A);
        send(1'b1, 7'h15, 8'h3C);
        wait_rises(6, "wait_bit10");
        bus.start = 1'b1;
        bus.rw    = 1'b0;
        bus.addr  = 7'h7F;
        bus.wdata = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("midchange");
        repeat (20) @(negedge clk);
        chk("no_extra_frame_busy", bus.busy, 0);

        // Reset during the high phase of bit 8 (bit 8 of 0x8B55 is 1).
        send(1'b1, 7'h0B, 8'h55);
        wait_rises(8, "wait_bit8");
        chk("pre_rst_sclk", bus.sclk, 1);
        chk("pre_rst_copi", bus.copi, 1);
        dc = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("rst_ncs", bus.ncs, 1);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_copi", bus.copi, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
`ifdef SPI_READBACK_EN
        chk("rst_rdata", bus.rdata, 0);
`endif
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (150) @(negedge clk);
        chk("no_done_after_abort", done_cnt, dc);
        push_exp(16'h8B55, 8'h5A);
        send(1'b1, 7'h0B, 8'h55);
        wait_done("after_abort");
        @(negedge clk);

        // rw=0 frame; the peripheral model returns 0xA5 in the data phase.
        resp = 8'hA5;
        push_exp(16'h1200, 8'hA5);
        send(1'b0, 7'h12, 8'h00);
        wait_done("rw0_frame");
        repeat (10) @(negedge clk);
`ifdef SPI_READBACK_EN
        chk("rdata_held", bus.rdata, 8'hA5);
`endif

        repeat (20) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("frames_decoded", frame_cnt, 6);
        chk("done_pulses", done_cnt, 6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
